// File: rtl/sd_pkg.sv
// sd_pkg: command/response codes and arbiter state encoding shared by the SD controller.
package sd_pkg;
  typedef enum logic [2:0] {NO_CMD, CMD0, CMD8, CMD58, CMD17, CMD24, CMD55, CMD41} cmd_e;
  localparam logic [7:0] RSP_NO_RSP      = 8'h00;
  localparam logic [7:0] RSP_IDLE        = 8'h01;
  localparam logic [7:0] RSP_ERASE_RESET = 8'h02;
  localparam logic [7:0] RSP_TIMEOUT     = 8'hFE;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACCEPT, ST_WAIT_RESP, ST_TO_RESP} arb_state_e;
endpackage

// File: rtl/sd_req_latch.sv
// sd_req_latch: one-deep command latch for a requester, with a sticky overrun flag.
module sd_req_latch (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_send,
  input  logic        i_clear,
  input  logic [2:0]  i_cmd,
  input  logic [31:0] i_arg,
  output logic        o_pending,
  output logic [2:0]  o_cmd,
  output logic [31:0] o_arg,
  output logic        o_overrun
);
  logic        pending_q, overrun_q;
  logic [2:0]  cmd_q;
  logic [31:0] arg_q;
  logic        take;
  // a send coinciding with the issue-cycle clear refills the slot instead of overrunning
  assign take = i_send && (!pending_q || i_clear);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      cmd_q     <= '0;
      arg_q     <= '0;
    end else begin
      pending_q <= take || (pending_q && !i_clear);
      overrun_q <= overrun_q || (i_send && !take);
      if (take) begin
        cmd_q <= i_cmd;
        arg_q <= i_arg;
      end
    end
  end
  assign o_pending = pending_q;
  assign o_cmd     = cmd_q;
  assign o_arg     = arg_q;
  assign o_overrun = overrun_q;
endmodule

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: fixed-priority sharing of the SD cmd module and CS line between two requesters.
// Define SD_CMD_TIMEOUT_EN to bound each confirm wait by TIMEOUT_CYCLES.
module sd_cmd_arbiter import sd_pkg::*; #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_send,
  input  logic [2:0]  i_req0_cmd,
  input  logic [31:0] i_req0_arg,
  input  logic        i_req0_cs,
  input  logic        i_req0_lock,
  output logic        o_req0_confirm,
  output logic [7:0]  o_req0_status,
  input  logic        i_req1_send,
  input  logic [2:0]  i_req1_cmd,
  input  logic [31:0] i_req1_arg,
  input  logic        i_req1_cs,
  input  logic        i_req1_lock,
  output logic        o_req1_confirm,
  output logic [7:0]  o_req1_status,
  output logic        o_send_cmd,
  output logic [2:0]  o_cmd_select,
  output logic [31:0] o_cmd_arg,
  input  logic        i_confirm_pin,
  input  logic [7:0]  i_response_status,
  output logic        o_sd_cs,
  output logic [1:0]  o_grant,
  output logic        o_busy,
  output logic [1:0]  o_overrun
);
  arb_state_e state_q, state_d;
  logic owner_q, owner_d, hold_q, hold_d;
  logic [N_REQ-1:0] grant_q, grant_d, send, lock, cs, pend, clr, elig;
  logic [N_REQ-1:0][2:0] lcmd;
  logic [N_REQ-1:0][31:0] larg;
  logic [N_REQ-1:0][7:0] status_q, status_d;
  logic [2:0] sel_q, sel_d;
  logic [31:0] arg_q, arg_d;
  logic waiting, tmo, fwd, rsp_done, rsp_to, eff_hold;
  logic [7:0] rsp_val;
  assign send = {i_req1_send, i_req0_send};
  assign lock = {i_req1_lock, i_req0_lock};
  assign cs   = {i_req1_cs, i_req0_cs};
  assign clr  = (state_q == ST_ISSUE) ? grant_q : '0;
  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    sd_req_latch u_latch (
      .i_clk(i_clk), .i_rst(i_rst), .i_send(send[g]), .i_clear(clr[g]),
      .i_cmd(g == 0 ? i_req0_cmd : i_req1_cmd), .i_arg(g == 0 ? i_req0_arg : i_req1_arg),
      .o_pending(pend[g]), .o_cmd(lcmd[g]), .o_arg(larg[g]), .o_overrun(o_overrun[g])
    );
  end
  assign waiting = state_q == ST_WAIT_ACCEPT || state_q == ST_WAIT_RESP;
`ifdef SD_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  assign tmo = waiting && !i_confirm_pin && tmr_q == TW'(TIMEOUT_CYCLES - 1);
  // reloads whenever a wait state is entered or a confirm arrives
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tmr_q <= '0;
    else tmr_q <= (state_d != state_q || i_confirm_pin) ? '0 : tmr_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif
  assign fwd      = (waiting && (i_confirm_pin || tmo)) || state_q == ST_TO_RESP;
  assign rsp_done = (state_q == ST_WAIT_RESP && (i_confirm_pin || tmo)) || state_q == ST_TO_RESP;
  assign rsp_to   = !(state_q == ST_WAIT_RESP && i_confirm_pin);
  assign rsp_val  = rsp_to ? RSP_TIMEOUT : i_response_status;
  assign eff_hold = hold_q && lock[owner_q];
  assign elig     = eff_hold ? (pend & (owner_q ? 2'b10 : 2'b01)) : pend;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    hold_d   = hold_q;
    sel_d    = sel_q;
    arg_d    = arg_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: begin
        hold_d = eff_hold;
        if (elig != '0) begin
          owner_d = !elig[0];
          grant_d = elig[0] ? 2'b01 : 2'b10;
          sel_d   = elig[0] ? lcmd[0] : lcmd[1];
          arg_d   = elig[0] ? larg[0] : larg[1];
          state_d = ST_ISSUE;
        end else if (!eff_hold) grant_d = '0;
      end
      ST_ISSUE: state_d = ST_WAIT_ACCEPT;
      ST_WAIT_ACCEPT: if (fwd) begin
        sel_d   = NO_CMD;
        state_d = i_confirm_pin ? ST_WAIT_RESP : ST_TO_RESP;
      end
      ST_WAIT_RESP, ST_TO_RESP: if (rsp_done) begin
        status_d[owner_q] = rsp_val;
        hold_d  = lock[owner_q] && !rsp_to;
        grant_d = (lock[owner_q] && !rsp_to) ? grant_q : '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      grant_q  <= '0;
      hold_q   <= 1'b0;
      sel_q    <= '0;
      arg_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      hold_q   <= hold_d;
      sel_q    <= sel_d;
      arg_q    <= arg_d;
      status_q <= status_d;
    end
  end
  assign o_send_cmd     = state_q == ST_ISSUE;
  assign o_cmd_select   = sel_q;
  assign o_cmd_arg      = arg_q;
  assign o_grant        = grant_q;
  assign o_busy         = state_q != ST_IDLE;
  assign o_sd_cs        = (grant_q == '0) ? 1'b1 : cs[owner_q];
  assign o_req0_confirm = fwd && !owner_q;
  assign o_req1_confirm = fwd && owner_q;
  assign o_req0_status  = (rsp_done && !owner_q) ? rsp_val : status_q[0];
  assign o_req1_status  = (rsp_done && owner_q) ? rsp_val : status_q[1];
endmodule

// File: doc/sd_cmd_arbiter.md
Name: sd_cmd_arbiter

Overview:
- Shares the single SD command module (command select, argument, send pulse, confirm, response status) and the SD CS line between two requesters.
- Requester 0 is the init sequencer. Requester 1 is the block read/write controller.
- Each requester latches one command, is granted by fixed priority, and sees a private copy of the cmd-module confirm/status handshake.
- Sits between the requesters and the cmd module inside the sd_card top.

Parameters:
- N_REQ, 2, number of requesters (fixed at 2 in this revision)
- TIMEOUT_CYCLES, 65535, cycles to wait for each confirm (used only with SD_CMD_TIMEOUT_EN)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_req0_send  in  1  one-cycle command request pulse, requester 0
- i_req0_cmd  in  3  command code, requester 0
- i_req0_arg  in  32  command argument, requester 0
- i_req0_cs  in  1  CS level requested by requester 0
- i_req0_lock  in  1  keep grant after completion (e.g. CMD55+CMD41 pair)
- o_req0_confirm  out  1  forwarded confirm pulse, requester 0
- o_req0_status  out  8  forwarded response status, requester 0
- i_req1_send, i_req1_cmd, i_req1_arg, i_req1_cs, i_req1_lock, o_req1_confirm, o_req1_status: same as requester 0, for requester 1
- o_send_cmd  out  1  send pulse to cmd module
- o_cmd_select  out  3  command code to cmd module
- o_cmd_arg  out  32  argument to cmd module
- i_confirm_pin  in  1  cmd-module confirm, one-cycle pulse per event
- i_response_status  in  8  cmd-module response code
- o_sd_cs  out  1  SD chip select
- o_grant  out  2  one-hot current owner (00 = none)
- o_busy  out  1  command in flight
- o_overrun  out  2  sticky per-requester overrun flags

Behaviour:
- Reset values:
  - all outputs 0, except o_sd_cs=1
  - state IDLE, owner=0, pending=00, lock_hold=0
- Cmd-module protocol: after o_send_cmd, two i_confirm_pin pulses arrive. The 1st means accepted; the 2nd carries a valid i_response_status.
- Request latch (per requester):
  - reqN_send with pending[N]=0 → pending[N]=1, capture cmd and arg.
  - reqN_send with pending[N]=1 → request dropped, o_overrun[N] set. Overrun flags clear only on reset.
- IDLE:
  - If lock_hold: only the owner's pending request is eligible.
  - Otherwise priority is req0 > req1.
  - On grant: owner=N, o_grant=onehot(N), go to ISSUE.
- ISSUE (1 cycle):
  - o_send_cmd=1; o_cmd_select/o_cmd_arg = latched values.
  - pending[N] cleared; o_busy=1; → WAIT_ACCEPT.
- WAIT_ACCEPT:
  - On i_confirm_pin: o_reqOwner_confirm=1 in the same cycle (combinational forward); o_cmd_select ← 0 (NO_CMD) next cycle; → WAIT_RESP.
- WAIT_RESP:
  - On i_confirm_pin: forward the confirm pulse, and o_reqOwner_status = i_response_status in the same cycle.
  - The status value is held registered until the next response to that requester.
  - Then: lock_hold ← i_reqOwner_lock; o_busy ← 0; → IDLE.
- Non-owner requesters never see a confirm. Their status output is unchanged.
- CS:
  - o_sd_cs = i_reqOwner_cs while the grant is valid.
  - When o_grant=00, o_sd_cs=1.
  - o_grant stays with the owner through IDLE while lock_hold=1; otherwise it clears to 00 on return to IDLE.
- Lock release: when the owner's lock drops while in IDLE, lock_hold ← 0 immediately and arbitration resumes the same cycle.
- Simultaneous send pulses from both requesters: both are latched; req0 is granted first, and req1 is issued in the next IDLE.
- A send pulse in the same cycle pending clears (ISSUE) is accepted as a new request, not an overrun.
- i_confirm_pin in IDLE or ISSUE: ignored.
- Reset mid-transaction: all state drops immediately; the cmd module is expected to be reset by the same i_rst.
- Latency: latched request to o_send_cmd is 2 cycles (IDLE, ISSUE) when the arbiter is idle.

Optional Feature:
SD_CMD_TIMEOUT_EN:
- Defined: a counter reloads on entering WAIT_ACCEPT/WAIT_RESP and on each confirm.
- At TIMEOUT_CYCLES without a confirm:
  - In WAIT_ACCEPT: emit a synthetic accept confirm, then the next cycle a confirm with status 8'hFE (RSP_TIMEOUT).
  - In WAIT_RESP: emit a single confirm with 8'hFE.
  - In both cases lock_hold ← 0 and → IDLE.
- Undefined: no counter; the arbiter waits indefinitely for confirms.

Decomposition:
- Package sd_pkg:
  - command codes NO_CMD..CMD41 (3-bit)
  - response codes Rsp_no_rsp..Rsp_erase_reset, plus RSP_TIMEOUT=8'hFE
  - arbiter state encoding
- Sub-module sd_req_latch, one instance per requester: pending flag, cmd/arg capture, overrun flag.

Test Plan:
- req0 sends CMD0, arg 0; cmd module confirms at +3 and +6 with status 1 → o_send_cmd at cycle 2, o_cmd_select=1, o_req0_confirm twice, o_req0_status=1, o_req1_confirm never.
- req0 and req1 pulse in the same cycle (CMD55 / CMD17, arg 0x200) → CMD55 issued first; CMD17 with arg 0x200 issued in the first IDLE after req0's response.
- req0 with lock=1 sends CMD55; req1 pulses CMD17 meanwhile; req0 then sends CMD41 → CMD41 issued before CMD17; o_grant stays 01; o_sd_cs follows i_req0_cs throughout.
- req1 pulses twice while pending → o_overrun=10; only the first command is issued.
- Reset asserted in WAIT_RESP → all outputs at reset values asynchronously; o_sd_cs=1; a new request afterwards is issued normally.
- With SD_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, no confirm → requester sees 2 confirms, status 8'hFE; o_busy=0 by cycle ~19.
